// File: rtl/axis_pkt_tx.sv
// rtl/axis_pkt_tx.sv - AXI-Stream packet transmitter emitting a framed byte-ramp payload per command
module axis_pkt_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [USER_WIDTH-1:0]   cmd_user,
    input  logic [7:0]              cmd_seed,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [DATA_WIDTH/8-1:0] m_keep,
    output logic                    m_last,
    output logic [USER_WIDTH-1:0]   m_user,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [15:0]             pkt_count
);
    localparam int B  = DATA_WIDTH / 8;
    localparam int CW = LEN_WIDTH + 1;

    typedef enum logic [0:0] {IDLE, SEND} state_t;
    state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [CW-1:0]         total_q;
    logic [CW-1:0]         idx_q;
    logic [7:0]            base_q;

    logic [LEN_WIDTH-1:0]  b_len;
    logic [CW-1:0]         b_total;
    logic [CW-1:0]         b_idx;
    logic [7:0]            b_base;
    logic [LEN_WIDTH-1:0]  b_rem;
    logic                  b_last;
    logic [DATA_WIDTH-1:0] b_data;
    logic [B-1:0]          b_keep;

    logic cmd_take;
    logic beat_xfer;
    logic load;
    logic done;

    // One extra bit so the all-ones length does not wrap the beat count.
    function automatic logic [CW-1:0] beats_of(input logic [LEN_WIDTH-1:0] len);
        return ({1'b0, len} + CW'(B - 1)) / CW'(B);
    endfunction

    assign cmd_take  = (state_q == IDLE) && cmd_valid && cmd_ready;
    assign beat_xfer = (state_q == SEND) && m_valid && m_ready;
    assign load      = (cmd_take && (cmd_len != '0)) || (beat_xfer && !m_last);
    assign done      = beat_xfer && m_last;

    // Next beat to register: the first beat of a new command, or the successor of the one on the bus.
    always_comb begin
        if (state_q == IDLE) begin
            b_len   = cmd_len;
            b_base  = cmd_seed;
            b_idx   = '0;
            b_total = beats_of(cmd_len);
        end else begin
            b_len   = len_q;
            b_base  = base_q;
            b_idx   = idx_q + CW'(1);
            b_total = total_q;
        end
        b_last = (b_idx == b_total - CW'(1));
        b_rem  = b_len % LEN_WIDTH'(B);
        b_data = '0;
        b_keep = '0;
        for (int l = 0; l < B; l++) begin
            if (!b_last || (b_rem == '0) || (LEN_WIDTH'(l) < b_rem)) begin
                b_data[8*l +: 8] = b_base + 8'(l);
                b_keep[l]        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_take && (cmd_len != '0)) state_d = SEND;
            SEND:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            m_keep    <= '0;
            m_user    <= '0;
            pkt_count <= '0;
            len_q     <= '0;
            total_q   <= '0;
            idx_q     <= '0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d == SEND);
            if (cmd_take) begin
                len_q   <= cmd_len;
                total_q <= beats_of(cmd_len);
                m_user  <= cmd_user;
            end
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= b_data;
                m_keep  <= b_keep;
                m_last  <= b_last;
                idx_q   <= b_idx;
                base_q  <= b_base + 8'(B);
            end else if (done) begin
                m_valid   <= 1'b0;
                m_last    <= 1'b0;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_tx.sv
// tb/tb_axis_pkt_tx.sv - scoreboard bench for axis_pkt_tx
module tb_axis_pkt_tx;
    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [1:0]  cmd_user;
    logic [7:0]  cmd_seed;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [1:0]  m_user;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [15:0] pkt_count;

    axis_pkt_tx #(.DATA_WIDTH(32), .USER_WIDTH(2), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_user(cmd_user), .cmd_seed(cmd_seed),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_user(m_user),
        .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .pkt_count(pkt_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  user;
    } beat_t;

    beat_t expq[$];
    int    total;
    int    bad;
    int    nbeats;
    bit    hold_pend;
    beat_t hold_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_pkt(input int len, input logic [7:0] seed, input logic [1:0] user);
        int    nb;
        beat_t e;
        nb = (len + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            e = '0;
            for (int b = 0; b < 4; b++) begin
                if (i * 4 + b < len) begin
                    e.data[8*b +: 8] = 8'(int'(seed) + i * 4 + b);
                    e.keep[b]        = 1'b1;
                end
            end
            e.last = (i == nb - 1);
            e.user = user;
            expq.push_back(e);
        end
    endtask

    // Scoreboard monitor: pops on every handshake and enforces the stall hold rule.
    always @(negedge clk) begin
        beat_t got;
        beat_t e;
        if (rst) begin
            got = '{data: m_data, keep: m_keep, last: m_last, user: m_user};
            if (hold_pend) begin
                total++;
                if (m_valid !== 1'b1 || got !== hold_val) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                             m_valid, got, hold_val);
                end
            end
            if (m_valid && m_ready) begin
                total++;
                nbeats++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got beat=%h, required no beat", got);
                end else begin
                    e = expq.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL beat: got data=%h keep=%h last=%b user=%h, required data=%h keep=%h last=%b user=%h",
                                 got.data, got.keep, got.last, got.user, e.data, e.keep, e.last, e.user);
                    end
                end
            end
            hold_pend = m_valid && !m_ready;
            hold_val  = got;
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic reset_dut();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int len, input logic [7:0] seed, input logic [1:0] user);
        bit ok;
        @(posedge clk);
        #1;
        cmd_len   = 16'(len);
        cmd_seed  = seed;
        cmd_user  = user;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                push_pkt(len, seed, user);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: got cmd_ready=0 for 200 cycles, required handshake");
        end
    endtask

    task automatic drain(input bit rnd, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            if (expq.size() == 0 && !busy && !m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0", expq.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_user  = '0;
        cmd_seed  = '0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_valid, m_last, m_data, m_keep, m_user, busy, pkt_count, cmd_ready} !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b last=%b data=%h keep=%h user=%h busy=%b cnt=%0d rdy=%b, required all 0",
                     m_valid, m_last, m_data, m_keep, m_user, busy, pkt_count, cmd_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        send_cmd(4, 8'h10, 2'd2);
        @(negedge clk);
        total++;
        if (m_valid !== 1'b1 || m_data !== 32'h13121110 || m_keep !== 4'hF || m_last !== 1'b1 || m_user !== 2'd2) begin
            bad++;
            $display("FAIL t1_beat: got valid=%b data=%h keep=%h last=%b user=%h, required 1 13121110 f 1 2",
                     m_valid, m_data, m_keep, m_last, m_user);
        end
        drain(1'b0, 50);
        total++;
        if (pkt_count !== 16'd1) begin
            bad++;
            $display("FAIL t1_count: got %0d, required 1", pkt_count);
        end
    endtask

    task automatic test_two_beat();
        m_ready = 1'b0;
        send_cmd(6, 8'hFE, 2'd1);
        @(negedge clk);
        total++;
        if (m_data !== 32'h0100FFFE || m_keep !== 4'hF || m_last !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL t2_beat0: got data=%h keep=%h last=%b busy=%b rdy=%b, required 0100fffe f 0 1 0",
                     m_data, m_keep, m_last, busy, cmd_ready);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (m_data !== 32'h00000302 || m_keep !== 4'h3 || m_last !== 1'b1) begin
            bad++;
            $display("FAIL t2_beat1: got data=%h keep=%h last=%b, required 00000302 3 1", m_data, m_keep, m_last);
        end
        drain(1'b0, 50);
        total++;
        if (pkt_count !== 16'd2) begin
            bad++;
            $display("FAIL t2_count: got %0d, required 2", pkt_count);
        end
    endtask

    task automatic test_stall();
        int nb0;
        nb0 = nbeats;
        m_ready = 1'b0;
        send_cmd(64, 8'h00, 2'd3);
        drain(1'b1, 400);
        total++;
        if (nbeats - nb0 !== 16) begin
            bad++;
            $display("FAIL t3_beats: got %0d, required 16", nbeats - nb0);
        end
        total++;
        if (pkt_count !== 16'd3) begin
            bad++;
            $display("FAIL t3_count: got %0d, required 3", pkt_count);
        end
    endtask

    task automatic test_zero_len();
        reset_dut();
        send_cmd(0, 8'h33, 2'd0);
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL t4_zero: got valid=%b busy=%b rdy=%b, required 0 0 1", m_valid, busy, cmd_ready);
        end
        send_cmd(1, 8'hAA, 2'd1);
        @(negedge clk);
        total++;
        if (m_data !== 32'h000000AA || m_keep !== 4'h1 || m_last !== 1'b1) begin
            bad++;
            $display("FAIL t4_beat: got data=%h keep=%h last=%b, required 000000aa 1 1", m_data, m_keep, m_last);
        end
        drain(1'b0, 50);
        total++;
        if (pkt_count !== 16'd1) begin
            bad++;
            $display("FAIL t4_count: got %0d, required 1", pkt_count);
        end
    endtask

    task automatic test_reset_mid();
        int nb0;
        bit ok;
        nb0 = nbeats;
        send_cmd(40, 8'h30, 2'd2);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #2;
            if (nbeats - nb0 >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL t5_progress: got %0d beats valid=%b, required 3 beats valid=1", nbeats - nb0, m_valid);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL t5_async: got valid=%b last=%b busy=%b rdy=%b, required 0 0 0 0", m_valid, m_last, busy, cmd_ready);
        end
        expq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || pkt_count !== 16'd0) begin
            bad++;
            $display("FAIL t5_after: got busy=%b cnt=%0d, required 0 0", busy, pkt_count);
        end
        send_cmd(8, 8'h55, 2'd3);
        @(negedge clk);
        total++;
        if (m_data !== 32'h58575655 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL t5_restart: got data=%h last=%b, required 58575655 0", m_data, m_last);
        end
        drain(1'b0, 50);
        total++;
        if (pkt_count !== 16'd1) begin
            bad++;
            $display("FAIL t5_count: got %0d, required 1", pkt_count);
        end
    endtask

    task automatic test_back_to_back();
        int       acc;
        int       cyc;
        int       last_hs;
        int       gap_bad;
        int       ready_bad;
        logic [7:0] seed;
        reset_dut();
        acc       = 0;
        cyc       = 0;
        last_hs   = 0;
        gap_bad   = 0;
        ready_bad = 0;
        seed      = 8'h01;
        m_ready   = 1'b1;
        cmd_len   = 16'd4;
        cmd_user  = 2'd1;
        cmd_seed  = seed;
        cmd_valid = 1'b1;
        for (int c = 0; c < 2000 && acc < 300; c++) begin
            @(negedge clk);
            cyc++;
            if (busy && cmd_ready) ready_bad++;
            if (cmd_ready) begin
                push_pkt(4, seed, 2'd1);
                if (m_valid !== 1'b0 || (acc > 0 && cyc - last_hs != 2)) gap_bad++;
                last_hs = cyc;
                acc++;
                @(posedge clk);
                #1;
                if (acc == 300) cmd_valid = 1'b0;
                seed     = seed + 8'd7;
                cmd_seed = seed;
            end
        end
        cmd_valid = 1'b0;
        drain(1'b0, 50);
        total++;
        if (acc !== 300) begin
            bad++;
            $display("FAIL t6_accepted: got %0d, required 300", acc);
        end
        total++;
        if (gap_bad !== 0 || ready_bad !== 0) begin
            bad++;
            $display("FAIL t6_timing: got gap errors=%0d ready-during-send=%0d, required 0 0", gap_bad, ready_bad);
        end
        total++;
        if (pkt_count !== 16'd300) begin
            bad++;
            $display("FAIL t6_count: got %0d, required 300", pkt_count);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        nbeats    = 0;
        hold_pend = 1'b0;
        test_reset();
        test_single();
        test_two_beat();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
